// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: frame-latched positions, writable opacity masks,
// 2-stage hit/priority pipeline and per-frame collision report. Option: SPRITE_FLIP_EN.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 32,
    parameter int H_WIDTH     = 11,
    parameter int V_WIDTH     = 10,
    parameter int ID_WIDTH    = $clog2(NUM_SPRITES + 1),
    parameter int OFS_WIDTH   = $clog2(SPRITE_SIZE),
    parameter int SEL_WIDTH   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_frame_start,
    input  logic [NUM_SPRITES*H_WIDTH-1:0] i_spr_x,
    input  logic [NUM_SPRITES*V_WIDTH-1:0] i_spr_y,
    input  logic [NUM_SPRITES-1:0]         i_spr_en,
`ifdef SPRITE_FLIP_EN
    input  logic [NUM_SPRITES-1:0]         i_spr_flip,
`endif
    input  logic                           i_mask_we,
    input  logic [SEL_WIDTH-1:0]           i_mask_sel,
    input  logic [2*OFS_WIDTH-1:0]         i_mask_addr,
    input  logic                           i_mask_bit,
    input  logic                           i_pix_valid,
    input  logic [H_WIDTH-1:0]             i_pix_h,
    input  logic [V_WIDTH-1:0]             i_pix_v,
    output logic                           o_pix_valid,
    output logic [ID_WIDTH-1:0]            o_obj_id,
    output logic [OFS_WIDTH-1:0]           o_local_x,
    output logic [OFS_WIDTH-1:0]           o_local_y,
    output logic                           o_overlap,
    output logic [NUM_SPRITES-1:0]         o_collide
);
    localparam int MASK_BITS = SPRITE_SIZE * SPRITE_SIZE;

    logic [H_WIDTH-1:0]                    act_x_reg [NUM_SPRITES];
    logic [V_WIDTH-1:0]                    act_y_reg [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]                act_en_reg;
    logic [MASK_BITS-1:0]                  mask_reg [NUM_SPRITES];
    logic signed [H_WIDTH:0]               dx_reg [NUM_SPRITES];
    logic signed [V_WIDTH:0]               dy_reg [NUM_SPRITES];
    logic                                  s1_valid_reg;
    logic [NUM_SPRITES-1:0]                hit;
    logic [NUM_SPRITES-1:0][OFS_WIDTH-1:0] lx;
    logic [NUM_SPRITES-1:0][OFS_WIDTH-1:0] ly;
    logic [NUM_SPRITES-1:0]                hit_reg;
    logic [NUM_SPRITES-1:0]                acc_reg;
    logic [ID_WIDTH-1:0]                   win_id;
    logic [OFS_WIDTH-1:0]                  win_x;
    logic [OFS_WIDTH-1:0]                  win_y;
    logic                                  win_overlap;
    logic                                  seen;
`ifdef SPRITE_FLIP_EN
    logic [NUM_SPRITES-1:0]                act_flip_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)           act_flip_reg <= '0;
        else if (i_frame_start) act_flip_reg <= i_spr_flip;
    end
`endif

    // Active set, stage-1 offsets and mask storage; masks reset to a fully opaque box.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_en_reg   <= '0;
            s1_valid_reg <= 1'b0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                act_x_reg[k] <= '0;
                act_y_reg[k] <= '0;
                dx_reg[k]    <= '0;
                dy_reg[k]    <= '0;
                mask_reg[k]  <= '1;
            end
        end else begin
            s1_valid_reg <= i_pix_valid;
            if (i_frame_start) act_en_reg <= i_spr_en;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (i_frame_start) begin
                    act_x_reg[k] <= i_spr_x[k*H_WIDTH +: H_WIDTH];
                    act_y_reg[k] <= i_spr_y[k*V_WIDTH +: V_WIDTH];
                end
                dx_reg[k] <= $signed({1'b0, i_pix_h}) - $signed({act_x_reg[k][H_WIDTH-1], act_x_reg[k]});
                dy_reg[k] <= $signed({1'b0, i_pix_v}) - $signed({act_y_reg[k][V_WIDTH-1], act_y_reg[k]});
                if (i_mask_we && i_mask_sel == SEL_WIDTH'(k))
                    mask_reg[k][i_mask_addr] <= i_mask_bit;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
`ifdef SPRITE_FLIP_EN
            // Mirroring about SPRITE_SIZE-1 is a bitwise invert for a power-of-two edge.
            assign lx[gi] = act_flip_reg[gi] ? ~dx_reg[gi][OFS_WIDTH-1:0] : dx_reg[gi][OFS_WIDTH-1:0];
`else
            assign lx[gi] = dx_reg[gi][OFS_WIDTH-1:0];
`endif
            assign ly[gi]  = dy_reg[gi][OFS_WIDTH-1:0];
            assign hit[gi] = act_en_reg[gi]
                           & ~dx_reg[gi][H_WIDTH] & (dx_reg[gi][H_WIDTH-1:OFS_WIDTH] == '0)
                           & ~dy_reg[gi][V_WIDTH] & (dy_reg[gi][V_WIDTH-1:OFS_WIDTH] == '0)
                           & mask_reg[gi][{ly[gi], lx[gi]}];
        end
    endgenerate

    always_comb begin
        win_id      = '0;
        win_x       = '0;
        win_y       = '0;
        win_overlap = 1'b0;
        seen        = 1'b0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            if (hit[k]) begin
                if (seen) begin
                    win_overlap = 1'b1;
                end else begin
                    win_id = ID_WIDTH'(k + 1);
                    win_x  = lx[k];
                    win_y  = ly[k];
                end
                seen = 1'b1;
            end
        end
    end

    // An overlap presented in the frame_start cycle belongs to the new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pix_valid <= 1'b0;
            o_obj_id    <= '0;
            o_local_x   <= '0;
            o_local_y   <= '0;
            o_overlap   <= 1'b0;
            o_collide   <= '0;
            hit_reg     <= '0;
            acc_reg     <= '0;
        end else begin
            o_pix_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_obj_id  <= win_id;
                o_local_x <= win_x;
                o_local_y <= win_y;
                o_overlap <= win_overlap;
                hit_reg   <= hit;
            end
            if (i_frame_start) o_collide <= acc_reg;
            acc_reg <= (i_frame_start ? {NUM_SPRITES{1'b0}} : acc_reg)
                     | ((o_pix_valid & o_overlap) ? hit_reg : {NUM_SPRITES{1'b0}});
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: randomized pixels and sprite sets checked
// against a direct geometric model of sprite coverage, priority and collisions.
module tb_sprite_compositor;
    localparam int NS  = 4;
    localparam int SZ  = 32;
    localparam int HW  = 11;
    localparam int VW  = 10;
    localparam int IDW = 3;
    localparam int OW  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic [NS*HW-1:0] spr_x;
    logic [NS*VW-1:0] spr_y;
    logic [NS-1:0]    spr_en;
    logic             mask_we = 1'b0;
    logic [1:0]       mask_sel = '0;
    logic [2*OW-1:0]  mask_addr = '0;
    logic             mask_bit = 1'b0;
    logic             pix_valid = 1'b0;
    logic [HW-1:0]    pix_h = '0;
    logic [VW-1:0]    pix_v = '0;
    logic             o_pix_valid;
    logic [IDW-1:0]   o_obj_id;
    logic [OW-1:0]    o_local_x;
    logic [OW-1:0]    o_local_y;
    logic             o_overlap;
    logic [NS-1:0]    o_collide;
`ifdef SPRITE_FLIP_EN
    logic [NS-1:0]    spr_flip = '0;
`endif

    sprite_compositor dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
        .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_en(spr_en),
`ifdef SPRITE_FLIP_EN
        .i_spr_flip(spr_flip),
`endif
        .i_mask_we(mask_we), .i_mask_sel(mask_sel), .i_mask_addr(mask_addr), .i_mask_bit(mask_bit),
        .i_pix_valid(pix_valid), .i_pix_h(pix_h), .i_pix_v(pix_v),
        .o_pix_valid(o_pix_valid), .o_obj_id(o_obj_id), .o_local_x(o_local_x),
        .o_local_y(o_local_y), .o_overlap(o_overlap), .o_collide(o_collide)
    );

    always #5 clk = ~clk;

    typedef struct {int id; int lx; int ly; int ovl;} exp_t;

    int      live_x [NS];
    int      live_y [NS];
    bit      live_en [NS];
    int      act_x [NS];
    int      act_y [NS];
    bit      act_en [NS];
    bit      mask_m [NS][SZ][SZ];
    bit [NS-1:0] acc_m;
    exp_t    q[$];
    exp_t    last_e;
    exp_t    mon_e;
    logic [1:0] vhist;
    int      vectors = 0;
    int      miscompares = 0;

    always_comb begin
        spr_x  = '0;
        spr_y  = '0;
        spr_en = '0;
        for (int k = 0; k < NS; k++) begin
            spr_x[k*HW +: HW] = HW'(live_x[k]);
            spr_y[k*VW +: VW] = VW'(live_y[k]);
            spr_en[k]         = live_en[k];
        end
    end

    function automatic void check(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    // Coverage, priority and overlap straight from sprite geometry.
    function automatic exp_t model(int h, int v, output bit [NS-1:0] hits);
        exp_t e;
        e.id = 0; e.lx = 0; e.ly = 0; e.ovl = 0;
        hits = '0;
        for (int k = 0; k < NS; k++) begin
            int dx = h - act_x[k];
            int dy = v - act_y[k];
            if (act_en[k] && dx >= 0 && dx < SZ && dy >= 0 && dy < SZ && mask_m[k][dy][dx]) begin
                hits[k] = 1'b1;
                if (e.id == 0) begin
                    e.id = k + 1; e.lx = dx; e.ly = dy;
                end
            end
        end
        e.ovl = ($countones(hits) >= 2) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) vhist <= '0;
        else        vhist <= {vhist[0], pix_valid};

    // Monitor: pops one expectation per presented pixel, checks holds otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_e.id = 0; last_e.lx = 0; last_e.ly = 0; last_e.ovl = 0;
        end else begin
            check("pix_valid_latency", int'(o_pix_valid), int'(vhist[1]));
            if (o_pix_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("obj_id", int'(o_obj_id), mon_e.id);
                    check("local_x", int'(o_local_x), mon_e.lx);
                    check("local_y", int'(o_local_y), mon_e.ly);
                    check("overlap", int'(o_overlap), mon_e.ovl);
                    $display("pix: id=%0d lx=%0d ly=%0d ovl=%0d (exp id=%0d)",
                             o_obj_id, o_local_x, o_local_y, o_overlap, mon_e.id);
                    last_e = mon_e;
                end
            end else begin
                check("hold_obj_id", int'(o_obj_id), last_e.id);
                check("hold_local_x", int'(o_local_x), last_e.lx);
                check("hold_overlap", int'(o_overlap), last_e.ovl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int h, int v);
        exp_t e;
        bit [NS-1:0] hits;
        e = model(h, v, hits);
        pix_valid = 1'b1;
        pix_h     = HW'(h);
        pix_v     = VW'(v);
        q.push_back(e);
        if (e.ovl != 0) acc_m |= hits;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    task automatic frame_pulse();
        bit [NS-1:0] exp_col;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_col = acc_m;
        acc_m   = '0;
        for (int k = 0; k < NS; k++) begin
            act_x[k] = live_x[k]; act_y[k] = live_y[k]; act_en[k] = live_en[k];
        end
        check("collide", int'(o_collide), int'(exp_col));
        $display("frame: collide=%b expected=%b", o_collide, exp_col);
    endtask

    task automatic mask_write(int sel, int row, int col, bit b);
        mask_we   = 1'b1;
        mask_sel  = 2'(sel);
        mask_addr = {OW'(row), OW'(col)};
        mask_bit  = b;
        tick();
        mask_we = 1'b0;
        mask_m[sel][row][col] = b;
    endtask

    task automatic model_reset();
        q.delete();
        acc_m = '0;
        for (int k = 0; k < NS; k++) begin
            act_x[k] = 0; act_y[k] = 0; act_en[k] = 1'b0;
            for (int r = 0; r < SZ; r++)
                for (int c = 0; c < SZ; c++) mask_m[k][r][c] = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_pix_valid"}, int'(o_pix_valid), 0);
        check({tag, "_obj_id"}, int'(o_obj_id), 0);
        check({tag, "_local_x"}, int'(o_local_x), 0);
        check({tag, "_local_y"}, int'(o_local_y), 0);
        check({tag, "_overlap"}, int'(o_overlap), 0);
        check({tag, "_collide"}, int'(o_collide), 0);
    endtask

    task automatic all_live_off();
        for (int k = 0; k < NS; k++) begin
            live_x[k] = 0; live_y[k] = 0; live_en[k] = 1'b0;
        end
    endtask

    initial begin
        all_live_off();
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // No frame latched yet: everything is background.
        for (int i = 0; i < 20; i++) begin
            issue(int'($urandom_range(0, 300)), int'($urandom_range(0, 200)));
            if ($urandom_range(0, 2) == 0) tick();
        end
        drain();
        check("collide_idle", int'(o_collide), 0);

        // Single sprite corners.
        live_x[0] = 100; live_y[0] = 50; live_en[0] = 1'b1;
        frame_pulse();
        issue(100, 50); issue(131, 81); issue(132, 50);
        drain();

        // Transparent pixel in sprite 0 lets sprite 2 through; overlap next door.
        all_live_off();
        live_x[0] = 10; live_y[0] = 10; live_en[0] = 1'b1;
        live_x[2] = 10; live_y[2] = 10; live_en[2] = 1'b1;
        frame_pulse();
        mask_write(0, 0, 0, 1'b0);
        issue(10, 10); issue(11, 10);
        drain();
        frame_pulse();
        check("collide_0101", int'(o_collide), 5);

        // Negative X, then live change without a frame pulse.
        all_live_off();
        live_x[1] = -5; live_y[1] = 60; live_en[1] = 1'b1;
        frame_pulse();
        issue(0, 60); issue(27, 60);
        drain();
        live_x[1] = 200;
        issue(0, 60); issue(205, 60);
        drain();
        frame_pulse();
        issue(0, 60); issue(205, 60);
        drain();

        // Randomized frames with mask edits.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NS; k++) begin
                live_x[k]  = int'($urandom_range(0, 100)) - 40;
                live_y[k]  = int'($urandom_range(0, 80)) - 40;
                live_en[k] = ($urandom_range(0, 3) != 0);
            end
            frame_pulse();
            for (int m = 0; m < 8; m++)
                mask_write(int'($urandom_range(0, NS-1)), int'($urandom_range(0, SZ-1)),
                           int'($urandom_range(0, SZ-1)), bit'($urandom_range(0, 1)));
            for (int p = 0; p < 60; p++) begin
                int k  = int'($urandom_range(0, NS-1));
                int hh = act_x[k] + int'($urandom_range(0, 40)) - 4;
                int vv = act_y[k] + int'($urandom_range(0, 40)) - 4;
                if (hh < 0) hh = 0;
                if (vv < 0) vv = 0;
                issue(hh, vv);
                if ($urandom_range(0, 3) == 0) tick();
            end
            drain();
        end
        frame_pulse();

        // Reset with pixels in flight: state, masks and pipeline all clear.
        issue(act_x[0] + 1, act_y[0] + 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NS; k++) begin
            live_x[k] = 20 * k; live_y[k] = 5 * k; live_en[k] = 1'b1;
        end
        frame_pulse();
        for (int p = 0; p < 30; p++)
            issue(int'($urandom_range(0, 100)), int'($urandom_range(0, 60)));
        drain();
        frame_pulse();

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
